// File: rtl/interleaver_prime_pkg.sv
// Shared types and helpers for the prime-multiplier interleaver.
// Bank lifecycle enum plus elaboration-time gcd and the modular address step.
package interleaver_prime_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  function automatic int unsigned gcd(input int unsigned a, input int unsigned b);
    int unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // (addr + p) mod n for addr < n, p < n: a single compare-subtract.
  function automatic int unsigned next_perm(input int unsigned addr, input int unsigned p,
                                            input int unsigned n);
    int unsigned s;
    s = addr + p;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/interleaver_prime_bank.sv
// One storage bank: L samples of register storage with asynchronous read,
// its lifecycle state and the mode bit latched on the block's first write.
module interleaver_prime_bank
  import interleaver_prime_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned L    = 10,
  parameter int unsigned AW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            wr_done,
  input  logic            mode_in,
  input  logic            rd_start,
  input  logic            rd_done,
  input  logic [AW-1:0]   rd_addr,
  output logic [BITS-1:0] rd_data,
  output logic            mode,
  output logic            writable,
  output logic            readable,
  output logic            filling
);

  bank_state_e state, state_next;
  logic [BITS-1:0] mem [L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BANK_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush)                               state_next = BANK_EMPTY;
    else if (rd_done)                        state_next = BANK_EMPTY;
    else if (rd_start)                       state_next = BANK_DRAINING;
    else if (wr_done)                        state_next = BANK_FULL;
    else if (wr_en && state == BANK_EMPTY)   state_next = BANK_FILLING;
  end

  always_comb begin
    writable = (state == BANK_EMPTY) || (state == BANK_FILLING);
    readable = (state == BANK_FULL) || (state == BANK_DRAINING);
    filling  = (state == BANK_FILLING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 1'b0;
      for (int unsigned i = 0; i < L; i++) mem[i] <= '0;
    end else if (flush) begin
      mode <= 1'b0;
      for (int unsigned i = 0; i < L; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      if (state == BANK_EMPTY) mode <= mode_in;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/interleaver_prime_stream.sv
// Double-buffered streaming interleaver: out[i] = in[(P*i) mod N] forward,
// inverse permutation in reverse; tail samples pass through in place.
module interleaver_prime_stream
  import interleaver_prime_pkg::*;
#(
  parameter int unsigned BITS      = 8,
  parameter int unsigned N         = 10,
  parameter int unsigned P         = 3,
  parameter int unsigned TAIL_BITS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode_reverse,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_first,
  output logic            out_last,
  output logic            length_err
);

  localparam int unsigned L  = N + TAIL_BITS;
  localparam int unsigned CW = $clog2(L + 1);
  localparam logic [CW-1:0] LAST = CW'(L - 1);
  localparam logic [CW-1:0] NLEN = CW'(N);
  localparam logic [CW-1:0] ONE  = CW'(1);

  if (!(P > 0 && P < N && gcd(N, P) == 1)) begin : g_bad_param
    $error("interleaver_prime_stream: require 0 < P < N and gcd(N,P) == 1");
  end

  logic          wr_ptr, rd_ptr;
  logic [CW-1:0] w, wa, r, ra;
  logic [CW-1:0] wr_addr, rd_addr;
  logic          accept, wr_done, readable, load, rd_start, rd_done;
  logic [1:0]    bank_writable, bank_readable, bank_filling, bank_mode;
  logic [1:0]    bank_wr_en, bank_wr_done, bank_rd_start, bank_rd_done;
  logic [BITS-1:0] bank_rd_data [2];

  always_comb begin
    in_ready = bank_writable[wr_ptr];
    accept   = in_valid && in_ready && !flush;
    wr_done  = accept && (w == LAST);
    // At w = 0 both modes target address 0, so the not-yet-latched mode is harmless.
    wr_addr  = (bank_mode[wr_ptr] && w < NLEN) ? wa : w;
    // A bank finishing its fill is readable the same cycle: address 0 is always written first.
    readable = bank_readable[rd_ptr] || (bank_filling[rd_ptr] && wr_done);
    load     = (!out_valid || out_ready) && readable && !flush;
    rd_start = load && (r == '0);
    rd_done  = load && (r == LAST);
    rd_addr  = (!bank_mode[rd_ptr] && r < NLEN) ? ra : r;
    bank_wr_en    = '0;
    bank_wr_done  = '0;
    bank_rd_start = '0;
    bank_rd_done  = '0;
    bank_wr_en[wr_ptr]    = accept;
    bank_wr_done[wr_ptr]  = wr_done;
    bank_rd_start[rd_ptr] = rd_start;
    bank_rd_done[rd_ptr]  = rd_done;
  end

  interleaver_prime_bank #(.BITS(BITS), .L(L), .AW(CW)) u_bank0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(bank_wr_en[0]), .wr_addr(wr_addr), .wr_data(in_data), .wr_done(bank_wr_done[0]),
    .mode_in(mode_reverse), .rd_start(bank_rd_start[0]), .rd_done(bank_rd_done[0]),
    .rd_addr(rd_addr), .rd_data(bank_rd_data[0]), .mode(bank_mode[0]),
    .writable(bank_writable[0]), .readable(bank_readable[0]), .filling(bank_filling[0])
  );

  interleaver_prime_bank #(.BITS(BITS), .L(L), .AW(CW)) u_bank1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(bank_wr_en[1]), .wr_addr(wr_addr), .wr_data(in_data), .wr_done(bank_wr_done[1]),
    .mode_in(mode_reverse), .rd_start(bank_rd_start[1]), .rd_done(bank_rd_done[1]),
    .rd_addr(rd_addr), .rd_data(bank_rd_data[1]), .mode(bank_mode[1]),
    .writable(bank_writable[1]), .readable(bank_readable[1]), .filling(bank_filling[1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w <= '0; wa <= '0; wr_ptr <= 1'b0; length_err <= 1'b0;
    end else if (flush) begin
      w <= '0; wa <= '0; wr_ptr <= 1'b0; length_err <= 1'b0;
    end else begin
      length_err <= accept && (in_last != (w == LAST));
      if (accept) begin
        if (w == LAST) begin
          w <= '0; wa <= '0; wr_ptr <= ~wr_ptr;
        end else begin
          w  <= w + ONE;
          wa <= CW'(next_perm(32'(wa), P, N));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0; ra <= '0; rd_ptr <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_first <= 1'b0; out_last <= 1'b0;
    end else if (flush) begin
      r <= '0; ra <= '0; rd_ptr <= 1'b0;
      out_valid <= 1'b0; out_data <= '0; out_first <= 1'b0; out_last <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= bank_rd_data[rd_ptr];
      out_first <= (r == '0);
      out_last  <= (r == LAST);
      if (r == LAST) begin
        r <= '0; ra <= '0; rd_ptr <= ~rd_ptr;
      end else begin
        r  <= r + ONE;
        ra <= CW'(next_perm(32'(ra), P, N));
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interleaver_prime_stream.sv
// Randomized and directed bench for interleaver_prime_stream against a
// block-level permutation model with a scoreboard queue.
module tb_interleaver_prime_stream;

  localparam int TN = 10;
  localparam int TP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       mode_reverse = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_first, out_last, length_err;
  logic [7:0] out_data;

  logic       t_in_valid = 1'b0;
  logic [7:0] t_in_data = '0;
  logic       t_in_last = 1'b0;
  logic       t_out_ready = 1'b1;
  logic       t_in_ready, t_out_valid, t_out_first, t_out_last, t_length_err;
  logic [7:0] t_out_data;

  interleaver_prime_stream #(.BITS(8), .N(TN), .P(TP), .TAIL_BITS(0)) dut (
    .clk(clk), .rst_n(rst_n), .mode_reverse(mode_reverse), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .length_err(length_err)
  );

  interleaver_prime_stream #(.BITS(8), .N(TN), .P(TP), .TAIL_BITS(2)) dut_tail (
    .clk(clk), .rst_n(rst_n), .mode_reverse(mode_reverse), .flush(flush),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data), .in_last(t_in_last),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
    .out_first(t_out_first), .out_last(t_out_last), .length_err(t_length_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] seen_q[$];
  int         seen_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         lerr_cnt = 0;
  bit         mon_en = 1'b0;
  bit         abort = 1'b0;
  bit         rnd_done = 1'b0;
  bit         hold_prev = 1'b0;
  logic [7:0] hold_d;
  logic       hold_f, hold_l;

  logic [7:0] fwd_ref [10] = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd2, 8'd5, 8'd8, 8'd1, 8'd4, 8'd7};
  logic [7:0] rev_ref [10] = '{8'd0, 8'd7, 8'd4, 8'd1, 8'd8, 8'd5, 8'd2, 8'd9, 8'd6, 8'd3};
  logic [7:0] tail_ref [12] = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd2, 8'd5, 8'd8, 8'd1, 8'd4, 8'd7,
                                8'd10, 8'd11};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: forward reads in[(P*i) mod N]; reverse writes in[i] to position (P*i) mod N.
  task automatic push_expected(input logic [7:0] x [10], input bit rev);
    logic [7:0] y [10];
    for (int i = 0; i < TN; i++) begin
      if (!rev) y[i] = x[(TP * i) % TN];
      else      y[(TP * i) % TN] = x[i];
    end
    for (int i = 0; i < TN; i++) exp_q.push_back('{d: y[i], f: (i == 0), l: (i == TN - 1)});
  endtask

  task automatic send_sample(input logic [7:0] d, input bit last);
    int n;
    bit ok;
    if (abort) return;
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0; ok = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) begin
      check("in_ready_timeout", 0, 1);
      abort = 1'b1; in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] x [10], input bit rev, input int bad, input bit gaps);
    mode_reverse = rev;
    for (int i = 0; i < TN; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_sample(x[i], (i == TN - 1) || (i == bad));
    end
    if (!abort) push_expected(x, rev);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
    check(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_first"}, out_first, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_length_err"}, length_err, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst_n && length_err) lerr_cnt++;
    if (mon_en && rst_n) begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
        check("hold_first", out_first, hold_f);
        check("hold_last", out_last, hold_l);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_first", out_first, e.f);
          check("out_last", out_last, e.l);
        end
        seen_q.push_back(out_data);
        seen_cyc.push_back(cyc);
      end
      hold_prev = out_valid && !out_ready;
      hold_d = out_data; hold_f = out_first; hold_l = out_last;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x [10];
    logic [7:0] y [10];
    int base, k, n;

    repeat (3) @(posedge clk);
    #1 check_idle("reset_low");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset");
    mon_en = 1'b1;

    // Forward 0..9, latency to first output.
    seen_q.delete();
    for (int i = 0; i < TN; i++) x[i] = 8'(i);
    send_block(x, 1'b0, -1, 1'b0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_first", out_first, 1);
    check("lat_data", out_data, 0);
    wait_drain("drain_fwd");
    for (int i = 0; i < TN; i++) check($sformatf("fwd_%0d", i), seen_q[i], fwd_ref[i]);

    // Reverse 0..9.
    seen_q.delete();
    send_block(x, 1'b1, -1, 1'b0);
    wait_drain("drain_rev");
    for (int i = 0; i < TN; i++) check($sformatf("rev_%0d", i), seen_q[i], rev_ref[i]);

    // Forward then reverse restores the original order.
    seen_q.delete();
    send_block(x, 1'b0, -1, 1'b0);
    wait_drain("drain_rt1");
    for (int i = 0; i < TN; i++) y[i] = seen_q[i];
    seen_q.delete();
    send_block(y, 1'b1, -1, 1'b0);
    wait_drain("drain_rt2");
    for (int i = 0; i < TN; i++) check($sformatf("restore_%0d", i), seen_q[i], i);

    // Back-to-back blocks produce a gapless output stream.
    seen_q.delete(); seen_cyc.delete();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
      send_block(x, b[0], -1, 1'b0);
    end
    wait_drain("drain_b2b");
    check("b2b_count", seen_q.size(), 30);
    if (seen_cyc.size() == 30) check("b2b_span", seen_cyc[29] - seen_cyc[0], 29);

    // Stall: two blocks fill both banks, output holds.
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
      send_block(x, b[0], -1, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("drain_stall");

    // Early in_last: one length error, block content unaffected.
    base = lerr_cnt;
    for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
    send_block(x, 1'b0, 5, 1'b0);
    wait_drain("drain_lerr");
    check("lerr_pulses", lerr_cnt - base, 1);

    // Random traffic with random backpressure.
    seen_q.delete();
    base = lerr_cnt;
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 100; b++) begin
          for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
          send_block(x, 1'($urandom_range(0, 1)), -1, 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1)); end
      end
    join
    out_ready = 1'b1;
    wait_drain("drain_rand");
    check("rand_count", seen_q.size(), 1000);
    check("rand_lerr", lerr_cnt - base, 0);

    // Asynchronous reset with one full and one partial block in flight.
    out_ready = 1'b0;
    for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
    send_block(x, 1'b0, -1, 1'b0);
    for (int i = 0; i < 5; i++) send_sample(8'($urandom), 1'b0);
    mon_en = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_idle("rst_mid");
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
    send_block(x, 1'b0, -1, 1'b0);
    wait_drain("drain_after_rst");

    // Flush with both banks occupied.
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
      send_block(x, 1'b0, -1, 1'b0);
    end
    @(negedge clk);
    check("flush_pre_in_ready", in_ready, 0);
    mon_en = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check_idle("flush");
    exp_q.delete();
    out_ready = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < TN; i++) x[i] = 8'($urandom);
    send_block(x, 1'b1, -1, 1'b0);
    wait_drain("drain_after_flush");

    // Tail samples pass through in place (TAIL_BITS = 2 instance).
    mode_reverse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      t_in_valid = 1'b1; t_in_data = 8'(i); t_in_last = (i == 11);
      n = 0;
      do begin @(negedge clk); n++; end while (!t_in_ready && n < 100);
      @(posedge clk); #1;
    end
    t_in_valid = 1'b0; t_in_last = 1'b0;
    k = 0; n = 0;
    while (k < 12 && n < 100) begin
      @(negedge clk); n++;
      if (t_out_valid) begin
        check($sformatf("tail_%0d", k), t_out_data, tail_ref[k]);
        check($sformatf("tail_first_%0d", k), t_out_first, (k == 0));
        check($sformatf("tail_last_%0d", k), t_out_last, (k == 11));
        k++;
      end
    end
    check("tail_count", k, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
